fifo_sync_flex: RTL and testbench
=================================

# fifo_sync_flex

Parametrised synchronous single-clock FIFO, the general-purpose buffer for all single-domain datapaths. It supports any depth of 2 or more, not only powers of two. It reports occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow errors, and provides a synchronous flush. First-word fall-through read mode is a build-time option.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of storage entries (≥2, any integer)
- AFULL_THRESH, DEPTH-1, almost_full asserts when count ≥ this value (1..DEPTH)
- AEMPTY_THRESH, 1, almost_empty asserts when count ≤ this value (0..AFULL_THRESH-1)
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of contents and error flags
- wr_en  in  1  write request
- data_in  in  WIDTH  write data
- rd_en  in  1  read request
- data_out  out  WIDTH  read data
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- almost_full  out  1  count ≥ AFULL_THRESH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Storage is exactly DEPTH entries. The write pointer and read pointer each range 0..DEPTH-1 and wrap from DEPTH-1 to 0 by explicit compare, not by modulo on a power of two.
- Write accept: wr_en & !full. The word is stored at wr_ptr and wr_ptr advances.
- Read accept: rd_en & !empty. rd_ptr advances.
- All accept decisions use the registered flags as they stand before the edge.
- Simultaneous wr_en & rd_en:
  - Neither full nor empty: both are accepted and count is unchanged.
  - When full: the read is accepted and the write is rejected.
  - When empty: the write is accepted and the read is rejected.
- count is a registered value: +1 on write only, −1 on read only, unchanged on both or neither. All four status flags are decoded from the registered count only, with no input-to-flag combinational path.
- Rejected write (wr_en & full): the data is dropped, memory and pointers are untouched, and overflow sets.
- Rejected read (rd_en & empty): no state changes except underflow, which sets.
- overflow and underflow stay set until flush or reset.
- flush has the highest priority. On a flush edge:
  - pointers, count, overflow and underflow go to 0;
  - the registered data_out goes to 0;
  - concurrent wr_en and rd_en are ignored and do not set error flags.
- Memory contents are not cleared by flush or reset.
- Reset values: data_out = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0.
- Reset is asynchronous. Asserting rstn low mid-transfer abandons all contents immediately.

## Timing
- Standard mode: data_out is registered.
  - On an accepted read at edge N, data_out carries the head word after edge N.
  - data_out holds its value on all other cycles.
  - Read latency is 1 cycle.
- FWFT mode: data_out is driven combinationally from mem[rd_ptr] whenever !empty, and is 0 when empty.
  - rd_en acts as a pop/acknowledge of the word currently shown.
- In both modes, a write accepted at edge N updates count and flags after edge N. In FWFT mode the word is visible on data_out from that point.
- Throughput is one write and one read per cycle, sustained.

## Configuration
- Macro FIFO_SYNC_FLEX_FWFT_EN.
- Defined: first-word fall-through read as described in Timing.
- Undefined (default): registered 1-cycle read.
- Count, flags, flush and error behaviour are identical in both modes.

## Test plan
- Wrap with non-power-of-two depth: WIDTH=8, DEPTH=5; write 0x10..0x14, read 5, write 0x20..0x22, read 3.
  - Data_out sequence must be 0x10..0x14 then 0x20..0x22.
  - The pointers must wrap past index 4, and count must return to 0 with empty=1.
- Full and overflow: fill to 5 (full=1, count=5), then write 0xAA.
  - overflow=1, count stays 5, 0xAA is never read out.
  - A following simultaneous rd+wr reads the head word, rejects the write, and leaves count=4.
- Empty and underflow: rd_en with empty=1.
  - underflow=1, count=0, data_out unchanged (standard) or 0 (FWFT).
  - A simultaneous rd+wr while empty leaves count=1.
- Thresholds: AFULL_THRESH=4, AEMPTY_THRESH=1.
  - Step count 0→5→0.
  - almost_empty must be high only for counts 0–1, almost_full only for counts 4–5, each flag changing one edge after the causing access.
- Flush: with count=3 and overflow=1, assert flush together with wr_en and rd_en.
  - Next cycle: count=0, empty=1, overflow=0, data_out=0.
  - The concurrent write is not stored.
- Async reset mid-stream: drop rstn between edges while count=2.
  - Outputs reach their reset values without waiting for a clock edge.
  - After release, the first written word is the first word read.

Source files
------------

// File: rtl/fifo_sync_flex_if.sv
// Handshake/data bundle for fifo_sync_flex. The producer/consumer side uses
// the master modport and the FIFO itself uses the slave modport.
interface fifo_sync_flex_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, count, empty, full, almost_empty, almost_full,
           overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, count, empty, full, almost_empty, almost_full,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flex.sv
// Synchronous single-clock FIFO of arbitrary DEPTH (>= 2), with registered
// occupancy count, almost-full/almost-empty thresholds, sticky overflow and
// underflow flags and a synchronous flush.
// Build option: define FIFO_SYNC_FLEX_FWFT_EN for first-word fall-through
// reads; otherwise data_out is registered with 1-cycle read latency.
module fifo_sync_flex #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input logic              clk,
  input logic              rstn,
  fifo_sync_flex_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             empty, full;
  logic             wr_acc, rd_acc;

  // Pointers wrap by explicit compare so any DEPTH works, not just powers of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flags come from the registered count only; no input reaches them.
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Accept decisions, pointer/count/error next-state; flush overrides everything.
  always_comb begin
    wr_acc   = bus.wr_en && !full  && !bus.flush;
    rd_acc   = bus.rd_en && !empty && !bus.flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_next(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_next(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (bus.wr_en && full)  ovf_d = 1'b1;
      if (bus.rd_en && empty) udf_d = 1'b1;
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; contents survive reset and flush by design.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

`ifdef FIFO_SYNC_FLEX_FWFT_EN
  // Head word shown combinationally whenever the FIFO holds data.
  always_comb begin
    bus.data_out = empty ? '0 : mem_q[rd_ptr_q];
  end
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  // Registered read port: load head word on an accepted read, else hold.
  always_comb begin
    dout_d = dout_q;
    if (bus.flush)  dout_d = '0;
    else if (rd_acc) dout_d = mem_q[rd_ptr_q];
  end

  // Read data register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign bus.data_out = dout_q;
`endif

  assign bus.count        = count_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_sync_flex.sv
// Self-checking bench for fifo_sync_flex (DEPTH=5, AFULL=4, AEMPTY=1).
// A queue-based model is compared against the DUT every falling clock edge;
// directed literal checks pin the model at key points.
module tb_fifo_sync_flex;
  localparam int W  = 8;
  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;

  logic clk;
  logic rstn;
  int   errors = 0;
  int   checks = 0;

  fifo_sync_flex_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fifo_sync_flex #(
    .WIDTH(W), .DEPTH(D), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] q [$];
  logic         m_ovf, m_udf;
  logic [W-1:0] m_dout;

  always @(posedge clk or negedge rstn) begin
    int n;
    if (!rstn) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = '0;
    end else if (bus.flush) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = '0;
    end else begin
      n = q.size();
      if (bus.wr_en && n == D) m_ovf = 1'b1;
      if (bus.rd_en && n == 0) m_udf = 1'b1;
      if (bus.rd_en && n != 0) m_dout = q.pop_front();
      if (bus.wr_en && n != D) q.push_back(bus.data_in);
    end
  end

  function automatic logic [W-1:0] model_dout();
`ifdef FIFO_SYNC_FLEX_FWFT_EN
    return (q.size() != 0) ? q[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("count",        32'(bus.count),        32'(n));
    chk("empty",        32'(bus.empty),        32'(n == 0));
    chk("full",         32'(bus.full),         32'(n == D));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    chk("almost_full",  32'(bus.almost_full),  32'(n >= AF));
    chk("overflow",     32'(bus.overflow),     32'(m_ovf));
    chk("underflow",    32'(bus.underflow),    32'(m_udf));
    chk("data_out",     32'(bus.data_out),     32'(model_dout()));
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic f);
    bus.wr_en   = w;
    bus.data_in = d;
    bus.rd_en   = r;
    bus.flush   = f;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic wr(input logic [W-1:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  // Pop one word and check it against a hand-written value.
  task automatic rd_exp(input logic [W-1:0] exp);
`ifdef FIFO_SYNC_FLEX_FWFT_EN
    chk("lit_rd", 32'(bus.data_out), 32'(exp));
    step(1'b0, '0, 1'b1, 1'b0);
`else
    step(1'b0, '0, 1'b1, 1'b0);
    chk("lit_rd", 32'(bus.data_out), 32'(exp));
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(bus.count),        32'd0);
    chk({tag, "_empty"}, 32'(bus.empty),        32'd1);
    chk({tag, "_full"},  32'(bus.full),         32'd0);
    chk({tag, "_ae"},    32'(bus.almost_empty), 32'd1);
    chk({tag, "_af"},    32'(bus.almost_full),  32'd0);
    chk({tag, "_ovf"},   32'(bus.overflow),     32'd0);
    chk({tag, "_udf"},   32'(bus.underflow),    32'd0);
    chk({tag, "_dout"},  32'(bus.data_out),     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ae_tab;
    logic [5:0] af_tab;
    ae_tab = 6'b000011;   // bit k = almost_empty at count k
    af_tab = 6'b110000;   // bit k = almost_full  at count k

    rstn        = 1'b0;
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;
    #3;
    chk_reset_vals("rst");
    @(negedge clk);
    rstn = 1'b1;

    // Wrap with DEPTH=5 and threshold walk 0 -> 5 -> 0.
    for (int unsigned i = 0; i < 5; i++) begin
      wr(8'h10 + 8'(i));
      chk("lit_cnt_up", 32'(bus.count), i + 1);
      chk("lit_ae_up",  32'(bus.almost_empty), 32'(ae_tab[i + 1]));
      chk("lit_af_up",  32'(bus.almost_full),  32'(af_tab[i + 1]));
    end
    chk("lit_full5", 32'(bus.full), 32'd1);
    for (int unsigned i = 0; i < 5; i++) begin
      rd_exp(8'h10 + 8'(i));
      chk("lit_ae_dn", 32'(bus.almost_empty), 32'(ae_tab[4 - i]));
      chk("lit_af_dn", 32'(bus.almost_full),  32'(af_tab[4 - i]));
    end
    for (int unsigned i = 0; i < 3; i++) wr(8'h20 + 8'(i));
    for (int unsigned i = 0; i < 3; i++) rd_exp(8'h20 + 8'(i));
    chk("lit_wrap_cnt",   32'(bus.count), 32'd0);
    chk("lit_wrap_empty", 32'(bus.empty), 32'd1);

    // Full and overflow.
    for (int unsigned i = 0; i < 5; i++) wr(8'h30 + 8'(i));
    wr(8'hAA);
    chk("lit_ovf",     32'(bus.overflow), 32'd1);
    chk("lit_ovf_cnt", 32'(bus.count),    32'd5);
`ifdef FIFO_SYNC_FLEX_FWFT_EN
    chk("lit_full_rw_head", 32'(bus.data_out), 32'h30);
    step(1'b1, 8'hBB, 1'b1, 1'b0);
`else
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    chk("lit_full_rw_head", 32'(bus.data_out), 32'h30);
`endif
    chk("lit_full_rw_cnt", 32'(bus.count), 32'd4);
    for (int unsigned i = 1; i < 5; i++) rd_exp(8'h30 + 8'(i));

    // Empty and underflow.
    step(1'b0, '0, 1'b1, 1'b0);
    chk("lit_udf",     32'(bus.underflow), 32'd1);
    chk("lit_udf_cnt", 32'(bus.count),     32'd0);
`ifdef FIFO_SYNC_FLEX_FWFT_EN
    chk("lit_udf_dout", 32'(bus.data_out), 32'h00);
`else
    chk("lit_udf_dout", 32'(bus.data_out), 32'h34);
`endif
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("lit_empty_rw_cnt", 32'(bus.count), 32'd1);

    // Flush with concurrent write and read.
    wr(8'h56);
    wr(8'h57);
    chk("lit_pre_flush_cnt", 32'(bus.count),    32'd3);
    chk("lit_pre_flush_ovf", 32'(bus.overflow), 32'd1);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("lit_fl_cnt",   32'(bus.count),     32'd0);
    chk("lit_fl_empty", 32'(bus.empty),     32'd1);
    chk("lit_fl_ovf",   32'(bus.overflow),  32'd0);
    chk("lit_fl_udf",   32'(bus.underflow), 32'd0);
    chk("lit_fl_dout",  32'(bus.data_out),  32'd0);
    wr(8'h60);
    rd_exp(8'h60);

    // Asynchronous reset mid-stream with count=2.
    wr(8'h70);
    wr(8'h71);
    chk("lit_pre_rst_cnt", 32'(bus.count), 32'd2);
    step(1'b0, '0, 1'b1, 1'b0);   // read one so data_out is non-zero in standard mode
    wr(8'h72);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    rstn = 1'b1;
    wr(8'h80);
    wr(8'h81);
    rd_exp(8'h80);
    rd_exp(8'h81);
    chk("lit_end_cnt", 32'(bus.count), 32'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
